regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset.
REQ-006 SHALL have ports: rd_addr in NRD*AW; rd_data out NRD*XLEN; rd_busy out NRD (pending bit of addressed register).
REQ-007 SHALL have ports: wr_en in NWR; wr_addr in NWR*AW; wr_data in NWR*XLEN (writeback, clears pending).
REQ-008 SHALL have ports: iss_en in 1; iss_addr in AW (marks destination register pending).
REQ-009 SHALL have ports: dump_start in 1; dump_ready in 1; dump_valid out 1; dump_idx out AW; dump_data out XLEN; dump_busy out 1; dump_last out 1 (debug/VGA scan stream).
REQ-010 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-011 SHALL hold register 0 at zero and never pending; writes and issues to address 0 SHALL be ignored.
REQ-012 SHALL commit wr_data[k] to wr_addr[k] at the rising clk edge when wr_en[k]=1; on address collision the highest-index port SHALL win.
REQ-013 SHALL read combinationally: rd_data[j] = stored value, except when an enabled write port targets the same non-zero address in that cycle, in which case that write's data (highest index wins) SHALL be forwarded.
REQ-014 SHALL set pending[iss_addr] at the edge when iss_en=1; SHALL clear pending[a] at the edge when any enabled write targets a; iss and write to the same address in one cycle SHALL leave pending set.
REQ-015 SHALL drive rd_busy[j] = pending[rd_addr[j]] AND NOT (any enabled write to rd_addr[j] this cycle) OR (iss_en AND iss_addr=rd_addr[j]), with address 0 always 0.
REQ-016 SHALL implement scan FSM with states IDLE and SCAN; IDLE->SCAN on dump_start=1, index loaded to 0.
REQ-017 In SCAN SHALL drive dump_valid=1, dump_idx=index, dump_data/dump_busy = stored (non-forwarded) value/pending of that index, dump_last=1 when index=NREG-1.
REQ-018 SHALL advance index by 1 on dump_valid AND dump_ready; on that handshake with index=NREG-1 SHALL return to IDLE next cycle.
REQ-019 SHALL hold dump_idx/dump_valid stable while dump_ready=0; dump_data MAY change if the scanned register is written.
REQ-020 SHALL ignore dump_start while in SCAN.
REQ-021 In IDLE SHALL drive dump_valid=0, dump_last=0, dump_idx=0, dump_data=0, dump_busy=0.

Reset
REQ-022 SHALL on rst=1 at a clk edge clear all registers and pending bits to 0, force FSM to IDLE, index 0, regardless of concurrent wr_en/iss_en/dump_start.
REQ-023 SHALL abort an in-progress scan on reset with no further dump_valid until a new dump_start.

Structure
REQ-024 SHALL place the scan FSM state enum (IDLE, SCAN) and the default XLEN/NREG constants in the shared pcpu package.
REQ-025 SHALL implement the scan FSM and index counter as sub-module regfile_scan; storage, forwarding and scoreboard stay in regfile_sb.

Verification
REQ-026 Reset, write x5=0x0000_00AA port0 -> next cycle rd_addr=5 gives 0xAA, rd_busy=0.
REQ-027 Same cycle: wr0 x7=0x11, wr1 x7=0x22, rd_addr=7 -> rd_data=0x22 combinationally, stored 0x22 after edge.
REQ-028 iss x9; next cycle rd_busy=1; write x9=0x5 with iss x9 same cycle -> pending stays 1, data 0x5.
REQ-029 Write x0=0xFFFF_FFFF, iss x0 -> rd_data=0, rd_busy=0.
REQ-030 dump_start, dump_ready toggled 1/0 -> exactly NREG handshakes idx 0..NREG-1, dump_last only on idx NREG-1, dump_start mid-scan ignored.
REQ-031 rst asserted at idx=10 of scan -> next cycle dump_valid=0, all registers read 0.

Source files
------------

// File: rtl/pcpu_pkg.sv
// ---------------------------------------------------------------------------
// pcpu_pkg
// Shared definitions for the pcpu register file slice.
//   XLEN_DEFAULT  : default register data width
//   NREG_DEFAULT  : default architectural register count
//   scan_state_e  : states of the register-file debug scan FSM
// ---------------------------------------------------------------------------
package pcpu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    // Debug scan FSM: IDLE waits for dump_start, SCAN streams one register
    // per dump_valid/dump_ready handshake.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/regfile_scan.sv
// ---------------------------------------------------------------------------
// regfile_scan
// Scan sequencer that walks register indices 0..NREG-1 for a debug / VGA
// dump stream. The register file owns the data; this block only owns the
// state and the index.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset (aborts any scan)
//   dump_start  in   begin a scan (ignored while a scan is running)
//   dump_ready  in   consumer accepts the current element
//   scan_valid  out  a scan element is presented
//   scan_idx    out  index of the presented element (0 while idle)
//   scan_last   out  presented element is register NREG-1
// ---------------------------------------------------------------------------
module regfile_scan
    import pcpu_pkg::*;
#(
    parameter  int NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          scan_valid,
    output logic [AW-1:0] scan_idx,
    output logic          scan_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

    scan_state_e   state_r;
    scan_state_e   state_nxt_s;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] idx_nxt_s;

    // State and index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state and index logic; index only moves on a completed handshake.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (dump_start) begin
                    state_nxt_s = SCAN;
                    idx_nxt_s   = IDX_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = IDX_ZERO;
                end
            end
            SCAN: begin
                if (dump_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = IDLE;
                        idx_nxt_s   = IDX_ZERO;
                    end else begin
                        state_nxt_s = SCAN;
                        idx_nxt_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    state_nxt_s = SCAN;
                    idx_nxt_s   = idx_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = IDX_ZERO;
            end
        endcase
    end

    // Stream qualifiers decoded from the state register; everything is
    // forced to zero while idle so the consumer sees a quiet bus.
    always_comb begin
        scan_valid = 1'b0;
        scan_idx   = IDX_ZERO;
        scan_last  = 1'b0;
        case (state_r)
            IDLE: begin
                scan_valid = 1'b0;
                scan_idx   = IDX_ZERO;
                scan_last  = 1'b0;
            end
            SCAN: begin
                scan_valid = 1'b1;
                scan_idx   = idx_r;
                scan_last  = (idx_r == LAST_IDX);
            end
            default: begin
                scan_valid = 1'b0;
                scan_idx   = IDX_ZERO;
                scan_last  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Multi-ported register file with a pending-bit scoreboard and a debug scan
// stream. Register 0 is hard-wired to zero and is never pending.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rd_addr      NRD packed read addresses
//   rd_data      NRD packed read data (write-forwarded, combinational)
//   rd_busy      NRD pending flags of the addressed registers
//   wr_en        NWR writeback enables
//   wr_addr      NWR packed writeback addresses
//   wr_data      NWR packed writeback data (a writeback clears pending)
//   iss_en       issue strobe, marks iss_addr pending
//   iss_addr     destination register of the issuing instruction
//   dump_start   start a register scan
//   dump_ready   scan consumer ready
//   dump_valid   scan element valid
//   dump_idx     scan element index
//   dump_data    stored value of the scanned register
//   dump_busy    pending bit of the scanned register
//   dump_last    scan element is the final register
// ---------------------------------------------------------------------------
module regfile_sb
    import pcpu_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    parameter  int NREG = NREG_DEFAULT,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [AW-1:0]     dump_idx,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_busy,
    output logic              dump_last
);

    localparam logic [AW-1:0]   ADDR_ZERO = {AW{1'b0}};
    localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

    // True when an enabled port targets addr; address 0 never matches so
    // writes to x0 are dropped and never forwarded.
    function automatic logic port_hit(
        input logic          en,
        input logic [AW-1:0] port_addr,
        input logic [AW-1:0] addr
    );
        return en && (port_addr == addr) && (addr != ADDR_ZERO);
    endfunction

    logic [XLEN-1:0] regs_r     [NREG];
    logic [XLEN-1:0] regs_nxt_s [NREG];
    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_nxt_s;

    logic [AW-1:0]   rd_addr_s [NRD];
    logic [AW-1:0]   wr_addr_s [NWR];
    logic [XLEN-1:0] wr_data_s [NWR];
    logic [XLEN-1:0] rd_val_s  [NRD];
    logic [NRD-1:0]  rd_hit_s;

    logic            scan_valid_s;
    logic [AW-1:0]   scan_idx_s;
    logic            scan_last_s;

    // Split the packed port buses into per-port views.
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_addr_s[j] = rd_addr[j*AW +: AW];
        end
        for (int k = 0; k < NWR; k++) begin
            wr_addr_s[k] = wr_addr[k*AW +: AW];
            wr_data_s[k] = wr_data[k*XLEN +: XLEN];
        end
    end

    // Next register/scoreboard contents. Ports are visited in ascending
    // order so the highest-index port wins a collision. The issue term is
    // OR-ed in after the writeback clear so a same-cycle issue keeps the
    // register pending.
    always_comb begin
        regs_nxt_s = regs_r;
        pend_nxt_s = pend_r;
        for (int a = 1; a < NREG; a++) begin
            for (int k = 0; k < NWR; k++) begin
                regs_nxt_s[a] = port_hit(wr_en[k], wr_addr_s[k], AW'(a))
                              ? wr_data_s[k] : regs_nxt_s[a];
                pend_nxt_s[a] = pend_nxt_s[a]
                              & ~port_hit(wr_en[k], wr_addr_s[k], AW'(a));
            end
            pend_nxt_s[a] = pend_nxt_s[a] | (iss_en && (iss_addr == AW'(a)));
        end
        regs_nxt_s[0] = DATA_ZERO;
        pend_nxt_s[0] = 1'b0;
    end

    // Storage and scoreboard registers; reset overrides any concurrent
    // writeback or issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NREG; a++) begin
                regs_r[a] <= DATA_ZERO;
            end
            pend_r <= {NREG{1'b0}};
        end else begin
            regs_r <= regs_nxt_s;
            pend_r <= pend_nxt_s;
        end
    end

    // Read ports: stored value with same-cycle writeback forwarding. Busy
    // reflects the pending bit as it will look after this edge would be
    // applied, so a consumer sees a writeback as already done and an issue
    // as already pending.
    always_comb begin
        rd_data  = {(NRD*XLEN){1'b0}};
        rd_busy  = {NRD{1'b0}};
        rd_hit_s = {NRD{1'b0}};
        for (int j = 0; j < NRD; j++) begin
            rd_val_s[j] = regs_r[rd_addr_s[j]];
            for (int k = 0; k < NWR; k++) begin
                rd_val_s[j] = port_hit(wr_en[k], wr_addr_s[k], rd_addr_s[j])
                            ? wr_data_s[k] : rd_val_s[j];
                rd_hit_s[j] = rd_hit_s[j]
                            | port_hit(wr_en[k], wr_addr_s[k], rd_addr_s[j]);
            end
            rd_data[j*XLEN +: XLEN] = (rd_addr_s[j] == ADDR_ZERO)
                                    ? DATA_ZERO : rd_val_s[j];
            rd_busy[j] = (rd_addr_s[j] != ADDR_ZERO)
                       && ((pend_r[rd_addr_s[j]] && !rd_hit_s[j])
                           || (iss_en && (iss_addr == rd_addr_s[j])));
        end
    end

    regfile_scan #(
        .NREG (NREG)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .scan_valid (scan_valid_s),
        .scan_idx   (scan_idx_s),
        .scan_last  (scan_last_s)
    );

    // Dump stream shows stored (not forwarded) contents; quiet while idle.
    always_comb begin
        dump_valid = scan_valid_s;
        dump_idx   = scan_idx_s;
        dump_last  = scan_last_s;
        dump_data  = scan_valid_s ? regs_r[scan_idx_s] : DATA_ZERO;
        dump_busy  = scan_valid_s & pend_r[scan_idx_s];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Directed self-checking bench for regfile_sb with default parameters
// (XLEN=32, NREG=32, NRD=2, NWR=2). Inputs change 1ns after the rising
// edge; outputs are sampled a further 1ns later.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 dump_start;
    logic                 dump_ready;
    logic                 dump_valid;
    logic [AW-1:0]        dump_idx;
    logic [XLEN-1:0]      dump_data;
    logic                 dump_busy;
    logic                 dump_last;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_regs [NREG];

    regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_last  (dump_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[k]               = 1'b1;
        wr_addr[k*AW +: AW]    = a;
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int j, input logic [AW-1:0] a);
        rd_addr[j*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rdd(input int j);
        return rd_data[j*XLEN +: XLEN];
    endfunction

    task automatic quiet();
        wr_en      = 2'b00;
        iss_en     = 1'b0;
        dump_start = 1'b0;
    endtask

    initial begin
        int  hs;
        bit  found;

        for (int a = 0; a < NREG; a++) exp_regs[a] = 32'h0;
        rst        = 1'b1;
        rd_addr    = '0;
        wr_en      = 2'b00;
        wr_addr    = '0;
        wr_data    = '0;
        iss_en     = 1'b0;
        iss_addr   = 5'd0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        set_rd(0, 5'd5);
        #1;
        check("rst_rd_data", rdd(0), 32'h0);
        check("rst_rd_busy", 32'(rd_busy[0]), 32'h0);
        check("rst_dump_valid", 32'(dump_valid), 32'h0);
        check("rst_dump_idx", 32'(dump_idx), 32'h0);
        check("rst_dump_data", dump_data, 32'h0);

        // Write x5 = 0xAA on port 0, read back next cycle
        set_wr(0, 5'd5, 32'h0000_00AA);
        step();
        quiet();
        set_rd(0, 5'd5);
        #1;
        check("x5_data", rdd(0), 32'h0000_00AA);
        check("x5_busy", 32'(rd_busy[0]), 32'h0);
        exp_regs[5] = 32'h0000_00AA;

        // Port collision on x7: port 1 wins, forwarded and then stored
        step();
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        set_rd(0, 5'd7);
        set_rd(1, 5'd7);
        #1;
        check("x7_fwd_p0", rdd(0), 32'h22);
        check("x7_fwd_p1", rdd(1), 32'h22);
        step();
        quiet();
        #1;
        check("x7_stored", rdd(1), 32'h22);
        exp_regs[7] = 32'h22;

        // Two different writes in one cycle
        step();
        set_wr(0, 5'd3, 32'h33);
        set_wr(1, 5'd4, 32'h44);
        step();
        quiet();
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        #1;
        check("x3_stored", rdd(0), 32'h33);
        check("x4_stored", rdd(1), 32'h44);
        exp_regs[3] = 32'h33;
        exp_regs[4] = 32'h44;

        // Issue x9: busy combinationally, then pending
        step();
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        set_rd(0, 5'd9);
        #1;
        check("x9_iss_comb_busy", 32'(rd_busy[0]), 32'h1);
        step();
        quiet();
        #1;
        check("x9_pending", 32'(rd_busy[0]), 32'h1);

        // Write x9 with a same-cycle issue of x9: stays pending
        step();
        set_wr(0, 5'd9, 32'h5);
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        #1;
        check("x9_wr_iss_comb_busy", 32'(rd_busy[0]), 32'h1);
        check("x9_wr_iss_fwd", rdd(0), 32'h5);
        step();
        quiet();
        #1;
        check("x9_wr_iss_busy", 32'(rd_busy[0]), 32'h1);
        check("x9_wr_iss_data", rdd(0), 32'h5);

        // Plain writeback clears pending (combinationally, then stored)
        step();
        set_wr(1, 5'd9, 32'h77);
        #1;
        check("x9_wb_comb_busy", 32'(rd_busy[0]), 32'h0);
        step();
        quiet();
        #1;
        check("x9_wb_busy", 32'(rd_busy[0]), 32'h0);
        check("x9_wb_data", rdd(0), 32'h77);
        exp_regs[9] = 32'h77;

        // x0 ignores writes and issues
        step();
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        set_rd(0, 5'd0);
        #1;
        check("x0_comb_data", rdd(0), 32'h0);
        check("x0_comb_busy", 32'(rd_busy[0]), 32'h0);
        step();
        quiet();
        #1;
        check("x0_data", rdd(0), 32'h0);
        check("x0_busy", 32'(rd_busy[0]), 32'h0);

        // Leave x12 pending so the scan shows a busy register
        step();
        iss_en   = 1'b1;
        iss_addr = 5'd12;
        step();
        quiet();

        // Full scan with dump_ready toggling and a mid-scan dump_start
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        hs = 0;
        for (int cyc = 0; cyc < 200 && hs < NREG; cyc++) begin
            dump_ready = (cyc % 2 == 0);
            dump_start = (hs == 15);
            #1;
            check("scan_valid", 32'(dump_valid), 32'h1);
            check("scan_idx", 32'(dump_idx), 32'(hs));
            if (dump_ready) begin
                check("scan_last", 32'(dump_last), (hs == NREG - 1) ? 32'h1 : 32'h0);
                check("scan_data", dump_data, exp_regs[hs]);
                check("scan_busy", 32'(dump_busy), (hs == 12) ? 32'h1 : 32'h0);
                hs++;
            end
            step();
        end
        dump_start = 1'b0;
        dump_ready = 1'b0;
        check("scan_handshakes", 32'(hs), 32'(NREG));
        #1;
        check("scan_end_valid", 32'(dump_valid), 32'h0);
        check("scan_end_last", 32'(dump_last), 32'h0);
        check("scan_end_idx", 32'(dump_idx), 32'h0);

        // Reset in the middle of a scan at index 10
        step();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            #1;
            if (dump_valid === 1'b1 && dump_idx === 5'd10) found = 1'b1;
            else step();
        end
        check("abort_reached_idx10", 32'(found), 32'h1);
        rst = 1'b1;
        set_wr(0, 5'd20, 32'hDEAD_BEEF);
        iss_en     = 1'b1;
        iss_addr   = 5'd21;
        dump_start = 1'b1;
        step();
        rst = 1'b0;
        quiet();
        #1;
        check("abort_valid", 32'(dump_valid), 32'h0);
        check("abort_idx", 32'(dump_idx), 32'h0);
        for (int a = 0; a < NREG; a++) begin
            set_rd(0, 5'(a));
            set_rd(1, 5'(a));
            #1;
            check("abort_reg_zero", rdd(0), 32'h0);
            check("abort_reg_busy", 32'(rd_busy[1]), 32'h0);
        end
        check("abort_stays_idle", 32'(dump_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
